// File: rtl/axi4_addr_map_checker.sv
// AXI4 address map and access-permission checker: programmable regions, 2-stage lookup,
// DECERR classification and saturating error statistics with first-error capture.
module axi4_addr_map_checker #(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned NUM_SLAVES    = 4,
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic [NUM_SLAVES*ADDRESS_WIDTH-1:0] RESET_BASE =
    {64'h20_0000_0000, 64'h10_0000_0000, 64'h0, 64'h100_0000_0000},
  parameter logic [NUM_SLAVES*ADDRESS_WIDTH-1:0] RESET_SIZE =
    {64'h1000, 64'h10_0000, 64'h2_0000, 64'h8_0000_0000},
  parameter logic [NUM_MASTERS*NUM_SLAVES-1:0] RESET_PERM =
    {4'b1001, 4'b0101, 4'b0101, 4'b1101},
  localparam int unsigned MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int unsigned SW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int unsigned AW1 = ADDRESS_WIDTH + 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MW-1:0]            req_master,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [7:0]               req_len,
  input  logic [2:0]               req_size,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  logic                     req_write,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SW-1:0]            rsp_slave,
  output logic                     rsp_hit,
  output logic [1:0]               rsp_resp,
  output logic [1:0]               rsp_cause,
  output logic [ID_WIDTH-1:0]      rsp_id,
  output logic                     rsp_write,
  input  logic                     cfg_wr_en,
  input  logic [1:0]               cfg_field,
  input  logic [7:0]               cfg_sel,
  input  logic [ADDRESS_WIDTH-1:0] cfg_wdata,
  output logic [CNT_WIDTH-1:0]     decerr_cnt,
  output logic                     err_valid,
  output logic [ADDRESS_WIDTH-1:0] err_addr,
  output logic [MW-1:0]            err_master,
  output logic [1:0]               err_cause,
  input  logic                     clr_err
);

  logic [ADDRESS_WIDTH-1:0] r_base [NUM_SLAVES];
  logic [ADDRESS_WIDTH-1:0] r_size [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]    r_perm [NUM_MASTERS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        r_base[s] <= RESET_BASE[s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        r_size[s] <= RESET_SIZE[s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
      for (int m = 0; m < NUM_MASTERS; m++) begin
        r_perm[m] <= RESET_PERM[m*NUM_SLAVES +: NUM_SLAVES];
      end
    end else if (cfg_wr_en) begin
      // Out-of-range selects match no entry and are dropped.
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (cfg_field == 2'd0 && cfg_sel == 8'(s)) r_base[s] <= cfg_wdata;
        if (cfg_field == 2'd1 && cfg_sel == 8'(s)) r_size[s] <= cfg_wdata;
      end
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (cfg_field == 2'd2 && cfg_sel == 8'(m)) r_perm[m] <= cfg_wdata[NUM_SLAVES-1:0];
      end
    end
  end

  logic                  w_s2_adv, w_s1_adv, w_accept;
  logic                  r_s1_valid, r_s2_valid;
  logic [AW1-1:0]        w_bytes, w_end;
  logic [NUM_SLAVES-1:0] w_hit, w_cross, w_perm;

  assign w_s2_adv  = !r_s2_valid || rsp_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign req_ready = !r_s1_valid || w_s1_adv;
  assign w_accept  = req_valid && req_ready;

  assign w_bytes = (AW1'(req_len) + AW1'(1)) << req_size;
  assign w_end   = {1'b0, req_addr} + w_bytes - AW1'(1);

  always_comb begin
    w_hit   = '0;
    w_cross = '0;
    w_perm  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_hit[s]   = (r_size[s] != '0) && (req_addr >= r_base[s]) &&
                   ((req_addr - r_base[s]) < r_size[s]);
      w_cross[s] = w_end[ADDRESS_WIDTH] || ((w_end - {1'b0, r_base[s]}) >= {1'b0, r_size[s]});
    end
    // An out-of-range master index selects nothing, leaving an all-zero mask.
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (req_master == MW'(m)) w_perm = r_perm[m];
    end
  end

  logic [NUM_SLAVES-1:0]    r_s1_hit, r_s1_cross, r_s1_perm;
  logic [ADDRESS_WIDTH-1:0] r_s1_addr, r_s2_addr;
  logic [MW-1:0]            r_s1_master, r_s2_master;
  logic [ID_WIDTH-1:0]      r_s1_id, r_s2_id;
  logic                     r_s1_write, r_s2_write, r_s2_hit;
  logic [SW-1:0]            r_s2_slave, w_slave;
  logic [1:0]               r_s2_resp, r_s2_cause, w_cause;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= '0;
      r_s1_cross  <= '0;
      r_s1_perm   <= '0;
      r_s1_addr   <= '0;
      r_s1_master <= '0;
      r_s1_id     <= '0;
      r_s1_write  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid  <= w_accept;
      r_s1_hit    <= w_hit;
      r_s1_cross  <= w_cross;
      r_s1_perm   <= w_perm;
      r_s1_addr   <= req_addr;
      r_s1_master <= req_master;
      r_s1_id     <= req_id;
      r_s1_write  <= req_write;
    end
  end

  always_comb begin
    w_slave = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (r_s1_hit[s]) w_slave = SW'(s);
    end
    w_cause = 2'd0;
    if (r_s1_hit == '0)        w_cause = 2'd1;
    else if (r_s1_cross[w_slave]) w_cause = 2'd3;
    else if (!r_s1_perm[w_slave]) w_cause = 2'd2;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s2_valid  <= 1'b0;
      r_s2_slave  <= '0;
      r_s2_hit    <= 1'b0;
      r_s2_resp   <= 2'b00;
      r_s2_cause  <= 2'd0;
      r_s2_addr   <= '0;
      r_s2_master <= '0;
      r_s2_id     <= '0;
      r_s2_write  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_slave  <= w_slave;
      r_s2_hit    <= (r_s1_hit != '0);
      r_s2_resp   <= (w_cause != 2'd0) ? 2'b11 : 2'b00;
      r_s2_cause  <= w_cause;
      r_s2_addr   <= r_s1_addr;
      r_s2_master <= r_s1_master;
      r_s2_id     <= r_s1_id;
      r_s2_write  <= r_s1_write;
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_slave = r_s2_slave;
  assign rsp_hit   = r_s2_hit;
  assign rsp_resp  = r_s2_resp;
  assign rsp_cause = r_s2_cause;
  assign rsp_id    = r_s2_id;
  assign rsp_write = r_s2_write;

  logic                     w_err_evt;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_err_valid;
  logic [ADDRESS_WIDTH-1:0] r_err_addr;
  logic [MW-1:0]            r_err_master;
  logic [1:0]               r_err_cause;

  assign w_err_evt = r_s2_valid && rsp_ready && (r_s2_resp == 2'b11);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt        <= '0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= '0;
      r_err_master <= '0;
      r_err_cause  <= 2'd0;
    end else if (clr_err) begin
      r_cnt        <= '0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= '0;
      r_err_master <= '0;
      r_err_cause  <= 2'd0;
    end else if (w_err_evt) begin
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (!r_err_valid) begin
        r_err_valid  <= 1'b1;
        r_err_addr   <= r_s2_addr;
        r_err_master <= r_s2_master;
        r_err_cause  <= r_s2_cause;
      end
    end
  end

  assign decerr_cnt = r_cnt;
  assign err_valid  = r_err_valid;
  assign err_addr   = r_err_addr;
  assign err_master = r_err_master;
  assign err_cause  = r_err_cause;

endmodule

// File: tb/tb_axi4_addr_map_checker.sv
// Directed bench for axi4_addr_map_checker; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_axi4_addr_map_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_master = '0;
  logic [63:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [3:0]  req_id = '0;
  logic        cfg_wr_en = 1'b0, clr_err = 1'b0;
  logic [1:0]  cfg_field = '0;
  logic [7:0]  cfg_sel = '0;
  logic [63:0] cfg_wdata = '0;

  logic        req_ready, rsp_valid, rsp_hit, rsp_write, err_valid;
  logic [1:0]  rsp_slave, rsp_resp, rsp_cause, err_master, err_cause;
  logic [3:0]  rsp_id;
  logic [15:0] decerr_cnt;
  logic [63:0] err_addr;

  logic        b_req_ready, b_rsp_valid, b_rsp_hit, b_rsp_write, b_err_valid;
  logic [1:0]  b_rsp_slave, b_rsp_resp, b_rsp_cause, b_err_master, b_err_cause;
  logic [3:0]  b_rsp_id;
  logic [1:0]  b_decerr_cnt;
  logic [63:0] b_err_addr;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4_addr_map_checker u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_master(req_master),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_id(req_id),
    .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slave(rsp_slave), .rsp_hit(rsp_hit),
    .rsp_resp(rsp_resp), .rsp_cause(rsp_cause), .rsp_id(rsp_id), .rsp_write(rsp_write),
    .cfg_wr_en(cfg_wr_en), .cfg_field(cfg_field), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .decerr_cnt(decerr_cnt), .err_valid(err_valid), .err_addr(err_addr),
    .err_master(err_master), .err_cause(err_cause), .clr_err(clr_err)
  );

  axi4_addr_map_checker #(.CNT_WIDTH(2)) u_dut_sat (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_master(req_master),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_id(req_id),
    .req_write(req_write),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_slave(b_rsp_slave),
    .rsp_hit(b_rsp_hit), .rsp_resp(b_rsp_resp), .rsp_cause(b_rsp_cause), .rsp_id(b_rsp_id),
    .rsp_write(b_rsp_write),
    .cfg_wr_en(cfg_wr_en), .cfg_field(cfg_field), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .decerr_cnt(b_decerr_cnt), .err_valid(b_err_valid), .err_addr(b_err_addr),
    .err_master(b_err_master), .err_cause(b_err_cause), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] m, input logic [63:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [3:0] id, input logic w);
    req_valid  = 1'b1;
    req_master = m;
    req_addr   = a;
    req_len    = l;
    req_size   = sz;
    req_id     = id;
    req_write  = w;
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [7:0] l,
                      input logic [2:0] sz, input logic [3:0] id, input logic w);
    drive_req(m, a, l, sz, id, w);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n;
    logic acc;
    logic [3:0] got [8];

    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_cnt", 64'(decerr_cnt), 64'd0);
    chk("reset_err_valid", 64'(err_valid), 64'd0);
    chk("reset_err_addr", err_addr, 64'd0);

    // M0 AR to slave 3: OKAY, two-cycle latency.
    send(2'd0, 64'h0000_0020_0000_0000, 8'd0, 3'd2, 4'd5, 1'b0);
    chk("lat_not_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("ok_valid", 64'(rsp_valid), 64'd1);
    chk("ok_slave", 64'(rsp_slave), 64'd3);
    chk("ok_hit", 64'(rsp_hit), 64'd1);
    chk("ok_resp", 64'(rsp_resp), 64'd0);
    chk("ok_cause", 64'(rsp_cause), 64'd0);
    chk("ok_id", 64'(rsp_id), 64'd5);
    chk("ok_write", 64'(rsp_write), 64'd0);
    step();

    // M1 AW to slave 3: permission denied.
    send(2'd1, 64'h0000_0020_0000_0010, 8'd0, 3'd2, 4'd6, 1'b1);
    step();
    chk("perm_resp", 64'(rsp_resp), 64'd3);
    chk("perm_cause", 64'(rsp_cause), 64'd2);
    chk("perm_write", 64'(rsp_write), 64'd1);
    step();
    chk("stat1_cnt", 64'(decerr_cnt), 64'd1);
    chk("stat1_err_valid", 64'(err_valid), 64'd1);
    chk("stat1_err_addr", err_addr, 64'h0000_0020_0000_0010);
    chk("stat1_err_master", 64'(err_master), 64'd1);
    chk("stat1_err_cause", 64'(err_cause), 64'd2);

    // M2 AR into the gap after slave 1: no hit.
    send(2'd2, 64'h0000_0000_0003_0000, 8'd0, 3'd2, 4'd7, 1'b0);
    step();
    chk("miss_hit", 64'(rsp_hit), 64'd0);
    chk("miss_slave", 64'(rsp_slave), 64'd0);
    chk("miss_resp", 64'(rsp_resp), 64'd3);
    chk("miss_cause", 64'(rsp_cause), 64'd1);
    step();
    chk("stat2_cnt", 64'(decerr_cnt), 64'd2);

    // M0 burst running past the end of slave 3.
    send(2'd0, 64'h0000_0020_0000_0FF0, 8'd7, 3'd2, 4'd3, 1'b0);
    step();
    chk("cross_slave", 64'(rsp_slave), 64'd3);
    chk("cross_resp", 64'(rsp_resp), 64'd3);
    chk("cross_cause", 64'(rsp_cause), 64'd3);
    step();
    chk("stat3_cnt", 64'(decerr_cnt), 64'd3);
    chk("stat3_err_addr", err_addr, 64'h0000_0020_0000_0010);

    // Stall: four back-to-back requests with rsp_ready low for five cycles.
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive_req(2'd0, 64'h0000_0020_0000_0000, 8'd0, 3'd2, 4'(8 + k), 1'b0);
      #1;
      acc = req_ready;
      step();
      if (acc) k++;
    end
    #1;
    chk("stall_accepted", 64'(k), 64'd2);
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("stall_rsp_id", 64'(rsp_id), 64'd8);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 4) drive_req(2'd0, 64'h0000_0020_0000_0000, 8'd0, 3'd2, 4'(8 + k), 1'b0);
      else req_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        if (n < 8) got[n] = rsp_id;
        n++;
      end
      step();
      if (acc) k++;
    end
    req_valid = 1'b0;
    chk("drain_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) chk("drain_order", 64'(got[i]), 64'(8 + i));

    // Permission write in the same cycle as an accepted M1 request.
    cfg_wr_en = 1'b1;
    cfg_field = 2'd2;
    cfg_sel   = 8'd1;
    cfg_wdata = 64'hD;
    drive_req(2'd1, 64'h0000_0020_0000_0010, 8'd0, 3'd2, 4'd1, 1'b0);
    step();
    cfg_wr_en = 1'b0;
    drive_req(2'd1, 64'h0000_0020_0000_0010, 8'd0, 3'd2, 4'd2, 1'b0);
    step();
    req_valid = 1'b0;
    chk("cfg_old_id", 64'(rsp_id), 64'd1);
    chk("cfg_old_resp", 64'(rsp_resp), 64'd3);
    chk("cfg_old_cause", 64'(rsp_cause), 64'd2);
    step();
    chk("cfg_new_id", 64'(rsp_id), 64'd2);
    chk("cfg_new_resp", 64'(rsp_resp), 64'd0);
    chk("cfg_new_slave", 64'(rsp_slave), 64'd3);
    step();
    chk("stat4_cnt", 64'(decerr_cnt), 64'd4);

    // Fifth DECERR: 16-bit counter keeps counting, 2-bit counter saturates.
    send(2'd2, 64'h0000_0000_0003_0000, 8'd0, 3'd2, 4'd4, 1'b0);
    step();
    step();
    chk("stat5_cnt", 64'(decerr_cnt), 64'd5);
    chk("sat_cnt", 64'(b_decerr_cnt), 64'd3);
    chk("sat_err_addr", b_err_addr, 64'h0000_0020_0000_0010);
    chk("stat5_err_addr", err_addr, 64'h0000_0020_0000_0010);
    chk("stat5_err_master", 64'(err_master), 64'd1);

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_cnt", 64'(decerr_cnt), 64'd0);
    chk("clr_err_valid", 64'(err_valid), 64'd0);
    chk("clr_err_addr", err_addr, 64'd0);
    chk("clr_err_master", 64'(err_master), 64'd0);
    chk("clr_sat_cnt", 64'(b_decerr_cnt), 64'd0);

    // Asynchronous reset with two requests in flight.
    drive_req(2'd0, 64'h0000_0020_0000_0000, 8'd0, 3'd2, 4'd12, 1'b0);
    step();
    drive_req(2'd0, 64'h0000_0020_0000_0000, 8'd0, 3'd2, 4'd13, 1'b0);
    step();
    req_valid = 1'b0;
    chk("inflight_rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid) n++;
    end
    chk("post_rst_no_rsp", 64'(n), 64'd0);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
